// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: adds two operands of 32*WORDS bits with a single
// 32-bit ripple adder. The adder is reused over WORDS cycles, one word per
// cycle, least-significant word first. The carry between words is held in a
// register. There are valid/ready handshakes on the input and output sides.
//
// Optional feature macro: WIDE_ADD_SUB_EN
//   When defined, the block has a sub_i port. If the captured sub_i is 1,
//   B is inverted word by word, so the result is A + ~B + carry_i.
//   With carry_i = 1 this is A - B, and carry_o = 1 means no borrow.
//   When the macro is undefined, the block only adds.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for operands; in_ready_o high
// RUN   | one word per cycle through the shared adder, idx = word
// DONE  | result held on sum_o/carry_o until the consumer takes it

module Ripple32Adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        carry_i,
    output logic [31:0] sum,
    output logic        carry_o
);

    // Bit-serial carry chain, written out explicitly as a ripple.
    always_comb begin
        logic c;
        c   = carry_i;
        sum = '0;
        for (int i = 0; i < 32; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        carry_o = c;
    end

endmodule

module wide_add_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [32*WORDS-1:0]   a_i,
    input  logic [32*WORDS-1:0]   b_i,
    input  logic                  carry_i,
`ifdef WIDE_ADD_SUB_EN
    input  logic                  sub_i,
`endif
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [32*WORDS-1:0]   sum_o,
    output logic                  carry_o,
    output logic                  busy_o
);

    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]              state;
    logic [WORDS-1:0][31:0]  a_q;
    logic [WORDS-1:0][31:0]  b_q;
    logic [WORDS-1:0][31:0]  sum_q;
    logic                    cy_q;
    logic [IW-1:0]           idx;

    logic [31:0]             add_a;
    logic [31:0]             add_b;
    logic [31:0]             add_sum;
    logic                    add_co;

`ifdef WIDE_ADD_SUB_EN
    logic                    sub_q;

    // Select the current word of B. It is inverted when subtracting.
    always_comb begin
        add_a = a_q[idx];
        add_b = sub_q ? ~b_q[idx] : b_q[idx];
    end
`else
    // Select the current word of A and of B.
    always_comb begin
        add_a = a_q[idx];
        add_b = b_q[idx];
    end
`endif

    Ripple32Adder u_adder (
        .a       (add_a),
        .b       (add_b),
        .carry_i (cy_q),
        .sum     (add_sum),
        .carry_o (add_co)
    );

    // Sequencer FSM: capture operands, step through the words, then hold the result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            sum_q <= '0;
            cy_q  <= 1'b0;
            idx   <= '0;
`ifdef WIDE_ADD_SUB_EN
            sub_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        a_q   <= a_i;
                        b_q   <= b_i;
                        cy_q  <= carry_i;
                        idx   <= '0;
`ifdef WIDE_ADD_SUB_EN
                        sub_q <= sub_i;
`endif
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum_q[idx] <= add_sum;
                    cy_q       <= add_co;
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs come only from registers and state. rst_i blocks ready during reset.
    always_comb begin
        in_ready_o  = (state == IDLE) && !rst_i;
        out_valid_o = (state == DONE);
        busy_o      = (state != IDLE);
        sum_o       = sum_q;
        carry_o     = cy_q;
    end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed testbench for wide_add_sequencer with WORDS = 4.
// The expected values were computed by hand.
module tb_wide_add_sequencer;

    localparam int WORDS = 4;
    localparam int W = 32 * WORDS;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    wide_add_sequencer #(.WORDS(WORDS)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .carry_i     (cin),
`ifdef WIDE_ADD_SUB_EN
        .sub_i       (sub),
`endif
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .sum_o       (sum),
        .carry_o     (cout),
        .busy_o      (busy)
    );

    // Present operands for exactly one clock edge. The caller checks in_ready first.
    task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic cv, input logic sv);
        a = av; b = bv; cin = cv; sub = sv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count the clock edges until out_valid rises. Give up after 20 edges.
    task automatic wait_valid(output int cycles, output bit timed_out);
        cycles = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            cycles++;
            if (out_valid) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++;
            if (in_ready !== 1'b0) $display("FAIL reset_in_ready_low got=%b exp=0", in_ready);
            else passed++;
        end
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        else passed++;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_valid_busy got=%b%b exp=00", out_valid, busy);
        else passed++;
        total++;
        if (sum !== '0 || cout !== 1'b0)
            $display("FAIL reset_sum got=%h/%b exp=0/0", sum, cout);
        else passed++;
    endtask

    task automatic test_full_ripple();
        int cyc; bit to;
        total++;
        if (in_ready !== 1'b1) $display("FAIL ripple_ready got=%b exp=1", in_ready);
        else passed++;
        accept({W{1'b1}}, 128'h1, 1'b0, 1'b0);
        total++;
        if (busy !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL ripple_busy got=%b%b exp=10", busy, out_valid);
        else passed++;
        wait_valid(cyc, to);
        total++;
        if (to || cyc != WORDS) $display("FAIL ripple_latency got=%0d timeout=%0d exp=%0d", cyc, to, WORDS);
        else passed++;
        total++;
        if (sum !== '0 || cout !== 1'b1)
            $display("FAIL ripple_sum got=%h/%b exp=0/1", sum, cout);
        else passed++;
        drain();
    endtask

    task automatic test_word_boundary();
        int cyc; bit to;
        accept(128'h0000_0000_FFFF_FFFF_FFFF_FFFF_0000_0001, 128'h1, 1'b1, 1'b0);
        wait_valid(cyc, to);
        total++;
        if (to || sum !== 128'h0000_0000_FFFF_FFFF_FFFF_FFFF_0000_0003 || cout !== 1'b0)
            $display("FAIL boundary1 got=%h/%b exp=00000000ffffffffffffffff00000003/0", sum, cout);
        else passed++;
        drain();
        accept(128'hFFFF_FFFF_0000_0000_0000_0000_FFFF_FFFF, 128'h1, 1'b0, 1'b0);
        wait_valid(cyc, to);
        total++;
        if (to || sum !== 128'hFFFF_FFFF_0000_0000_0000_0001_0000_0000 || cout !== 1'b0)
            $display("FAIL boundary2 got=%h/%b exp=ffffffff000000000000000100000000/0", sum, cout);
        else passed++;
        drain();
    endtask

    task automatic test_back_to_back();
        int cyc; bit to; int bad;
        accept(128'h0000_0001_0000_0002_0000_0003_0000_0004,
               128'h0000_0010_0000_0020_0000_0030_0000_0040, 1'b0, 1'b0);
        wait_valid(cyc, to);
        total++;
        if (to) $display("FAIL bp_timeout got=timeout exp=valid");
        else passed++;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || cout !== 1'b0 ||
                sum !== 128'h0000_0011_0000_0022_0000_0033_0000_0044) bad++;
        end
        total++;
        if (bad != 0) $display("FAIL bp_hold got=%0d bad cycles exp=0 (sum=%h)", bad, sum);
        else passed++;
        drain();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL bp_release got=%b%b exp=10", in_ready, out_valid);
        else passed++;
        accept(128'h8000_0000_0000_0000_0000_0000_0000_0000,
               128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b1, 1'b0);
        wait_valid(cyc, to);
        total++;
        if (to || cyc != WORDS || sum !== 128'h1 || cout !== 1'b1)
            $display("FAIL b2b_result got=%h/%b lat=%0d exp=1/1 lat=%0d", sum, cout, cyc, WORDS);
        else passed++;
        drain();
    endtask

    task automatic test_reset_mid_op();
        int seen;
        int cyc; bit to;
        accept({W{1'b1}}, {W{1'b1}}, 1'b1, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if (busy !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", busy);
        else passed++;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        total++;
        if (seen != 0) $display("FAIL midrst_valid got=%0d exp=0", seen);
        else passed++;
        accept(128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 128'h1, 1'b1, 1'b0);
        wait_valid(cyc, to);
        total++;
        if (to || sum !== 128'h0000_0000_0000_0001_0000_0000_0000_0001 || cout !== 1'b0)
            $display("FAIL midrst_next got=%h/%b exp=00000000000000010000000000000001/0", sum, cout);
        else passed++;
        drain();
    endtask

`ifdef WIDE_ADD_SUB_EN
    task automatic test_subtract();
        int cyc; bit to;
        accept(128'h5, 128'h7, 1'b1, 1'b1);
        wait_valid(cyc, to);
        total++;
        if (to || sum !== {{(W-2){1'b1}}, 2'b10} || cout !== 1'b0)
            $display("FAIL sub_neg got=%h/%b exp=ff..fe/0", sum, cout);
        else passed++;
        drain();
        accept(128'h7, 128'h5, 1'b1, 1'b1);
        wait_valid(cyc, to);
        total++;
        if (to || sum !== 128'h2 || cout !== 1'b1)
            $display("FAIL sub_pos got=%h/%b exp=2/1", sum, cout);
        else passed++;
        drain();
    endtask
`endif

    initial begin
        test_reset();
        test_full_ripple();
        test_word_boundary();
        test_back_to_back();
        test_reset_mid_op();
`ifdef WIDE_ADD_SUB_EN
        test_subtract();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
